// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand width and the count-down counter width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } div_state_t;

    localparam int DIV_N = 4;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mag_sign_conv.sv
// Two's-complement sign/magnitude converter. With to_mag=1 it splits a signed
// value into sign and unsigned magnitude; with to_mag=0 it applies sign_in to a magnitude.
module mag_sign_conv #(
    parameter int W = 4
) (
    input  logic         to_mag,
    input  logic         sign_in,
    input  logic [W-1:0] x,
    output logic         sign_out,
    output logic [W-1:0] y
);

    // Negating the most-negative value yields 2^(W-1), which is still correct read as unsigned.
    assign sign_out = to_mag ? x[W-1] : sign_in;
    assign y        = sign_out ? -x : x;

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor, truncating toward
// zero, one restoring step per clock on magnitudes followed by a sign fix-up cycle.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [2*N-1:0] D,
    input  logic [N-1:0]   V,
    output logic [N-1:0]   Qo,
    output logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = count_width(N);
    localparam logic [N-1:0] QMAX_POS = N'((1 << (N - 1)) - 1);
    localparam logic [N-1:0] QMAX_NEG = N'(1 << (N - 1));

    div_state_t     state;
    logic [CW-1:0]  count;
    logic [N-1:0]   pr;
    logic [N-1:0]   qs;
    logic [N-1:0]   abs_v;
    logic           s_d;
    logic           s_v;

    logic           d_sign;
    logic           v_sign;
    logic [2*N-1:0] abs_d_in;
    logic [N-1:0]   abs_v_in;
    logic           q_neg;
    logic           r_sign_unused;
    logic [N-1:0]   q_val;
    logic [N-1:0]   r_val;
    logic [N:0]     trial;
    logic           q_too_big;

    mag_sign_conv #(.W(2 * N)) u_dividend_mag (
        .to_mag   (1'b1),
        .sign_in  (1'b0),
        .x        (D),
        .sign_out (d_sign),
        .y        (abs_d_in)
    );

    mag_sign_conv #(.W(N)) u_divisor_mag (
        .to_mag   (1'b1),
        .sign_in  (1'b0),
        .x        (V),
        .sign_out (v_sign),
        .y        (abs_v_in)
    );

    mag_sign_conv #(.W(N)) u_quotient_fix (
        .to_mag   (1'b0),
        .sign_in  (s_d ^ s_v),
        .x        (qs),
        .sign_out (q_neg),
        .y        (q_val)
    );

    mag_sign_conv #(.W(N)) u_remainder_fix (
        .to_mag   (1'b0),
        .sign_in  (s_d),
        .x        (pr),
        .sign_out (r_sign_unused),
        .y        (r_val)
    );

    // The partial remainder stays below |V| <= 2^(N-1), so N bits hold it and
    // the (N+1)-bit trial difference carries the restore decision in its top bit.
    assign trial     = {pr, qs[N-1]} - {1'b0, abs_v};
    assign q_too_big = q_neg ? (qs > QMAX_NEG) : (qs > QMAX_POS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            pr    <= '0;
            qs    <= '0;
            abs_v <= '0;
            s_d   <= 1'b0;
            s_v   <= 1'b0;
            Qo    <= '0;
            R     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        s_d   <= d_sign;
                        s_v   <= v_sign;
                        abs_v <= abs_v_in;
                        pr    <= abs_d_in[2*N-1:N];
                        qs    <= abs_d_in[N-1:0];
                        count <= CW'(N);
                        if (V == '0) begin
                            done <= 1'b1;
                            dz   <= 1'b1;
                            ovf  <= 1'b0;
                            Qo   <= '0;
                            R    <= '0;
                        end else if (abs_d_in[2*N-1:N] >= abs_v_in) begin
                            done <= 1'b1;
                            dz   <= 1'b0;
                            ovf  <= 1'b1;
                            Qo   <= '0;
                            R    <= '0;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    if (!trial[N]) begin
                        pr <= trial[N-1:0];
                        qs <= {qs[N-2:0], 1'b1};
                    end else begin
                        pr <= {pr[N-2:0], qs[N-1]};
                        qs <= {qs[N-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (q_too_big) begin
                        ovf <= 1'b1;
                        Qo  <= '0;
                        R   <= '0;
                    end else begin
                        ovf <= 1'b0;
                        Qo  <= q_val;
                        R   <= r_val;
                    end
                    dz    <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: expected results are queued at
// load time and compared, together with their completion cycle, when done pulses.
module tb_seq_signed_divider;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] qo;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        int           due;
    } exp_t;

    logic           clk;
    logic           reset;
    logic           load;
    logic [2*N-1:0] D;
    logic [N-1:0]   V;
    logic [N-1:0]   Qo;
    logic [N-1:0]   R;
    logic           busy;
    logic           done;
    logic           dz;
    logic           ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    seq_signed_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .D     (D),
        .V     (V),
        .Qo    (Qo),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Reference model: integer division truncates toward zero and % takes the dividend's sign.
    function automatic exp_t model(input int d, input int v, input int due_base);
        exp_t e;
        int   qi, ri, ad, av;
        e.qo  = '0;
        e.r   = '0;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.due = due_base;
        if (v == 0) begin
            e.dz = 1'b1;
        end else begin
            qi = d / v;
            ri = d % v;
            ad = (d < 0) ? -d : d;
            av = (v < 0) ? -v : v;
            if (ad < av * (1 << N)) e.due = due_base + N + 1;
            if (qi > (1 << (N - 1)) - 1 || qi < -(1 << (N - 1))) begin
                e.ovf = 1'b1;
            end else begin
                e.qo = N'(qi);
                e.r  = N'(ri);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("Qo", int'(Qo), int'(e.qo));
                checkOutput("R", int'(R), int'(e.r));
                checkOutput("dz", int'(dz), int'(e.dz));
                checkOutput("ovf", int'(ovf), int'(e.ovf));
                checkOutput("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic applyStimulus(input int d, input int v);
        @(negedge clk);
        sb.push_back(model(d, v, cyc + 1));
        D    = (2 * N)'(d);
        V    = N'(v);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Raises load without expecting a result: for aborted or ignored requests.
    task automatic driveLoad(input int d, input int v);
        @(negedge clk);
        D    = (2 * N)'(d);
        V    = N'(v);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic waitIdle();
        int i = 0;
        while ((sb.size() != 0 || busy) && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (i >= 60) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    int dvec[] = '{-17, 30, 17, -32, 32, 64, 15, 15, -128, -64, -60, 127};
    int vvec[] = '{5, -6, -5, 4, 4, 4, 0, 3, -8, -8, -8, -8};

    initial begin
        int   busy_cycles;
        logic got;

        reset = 1'b1;
        load  = 1'b0;
        D     = '0;
        V     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_Qo", int'(Qo), 0);
        checkOutput("reset_R", int'(R), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_dz", int'(dz), 0);
        checkOutput("reset_ovf", int'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(15, 5);
        busy_cycles = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        checkOutput("busy_cycles", busy_cycles, N + 1);
        waitIdle();

        for (int k = 0; k < dvec.size(); k++) begin
            applyStimulus(dvec[k], vvec[k]);
            waitIdle();
        end

        // Abort an operation two cycles in; no done may follow.
        driveLoad(15, 5);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_Qo", int'(Qo), 0);
        checkOutput("abort_R", int'(R), 0);
        checkOutput("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(-15, 3);
        waitIdle();

        // A load pulse during the operation must be ignored.
        applyStimulus(15, 5);
        @(negedge clk);
        driveLoad(-100, 3);
        waitIdle();
        repeat (3) @(negedge clk);

        // Load held through the done cycle starts the next operation at once.
        @(negedge clk);
        sb.push_back(model(15, 5, cyc + 1));
        D    = (2 * N)'(15);
        V    = N'(5);
        load = 1'b1;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) checkOutput("b2b_first_done", 0, 1);
        sb.push_back(model(-17, 5, cyc + 1));
        D = (2 * N)'(-17);
        V = N'(5);
        @(posedge clk);
        #1 load = 1'b0;
        waitIdle();

        for (int k = 0; k < 10; k++) begin
            applyStimulus(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)) - 8);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed divider; the inverse of the team's sequential Booth multiplier.
- Divides a 2N-bit two's-complement dividend (a multiplier product P) by an N-bit divisor.
- Returns an N-bit quotient and an N-bit remainder, truncating toward zero, using one restoring step per clock on magnitudes.
- Sits beside the multiplier in the arithmetic datapath and uses the same load-start, count-down style.

Parameters:
N, 4, divisor/quotient/remainder width; dividend is 2N bits (N ≥ 2)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
load  in  1  start request; sampled only in IDLE
D  in  2N  signed dividend
V  in  N  signed divisor
Qo  out  N  signed quotient
R  out  N  signed remainder, same sign as D (or 0)
busy  out  1  high while in DIV or FIX
done  out  1  one-cycle pulse when Qo/R/flags are valid
dz  out  1  divide-by-zero flag, valid with done
ovf  out  1  quotient-overflow flag, valid with done

Behaviour:
- Reset: synchronous; when reset=1 at a rising edge, state=IDLE and Qo, R, busy, done, dz, ovf, Count and internal registers all go to 0. Reset overrides load and aborts any operation in progress; no done follows.
- States: IDLE, DIV, FIX. Count is ceil(log2(N+1)) bits.
- IDLE: load=1 at edge E0 does the following:
  - latch sD=D[2N-1], sV=V[N-1];
  - magnitude |D| (2N bits unsigned) and |V| (N bits unsigned);
  - partial remainder PR (N+1 bits) = |D|[2N-1:N]; quotient shift register QS = |D|[N-1:0];
  - Count=N.
- Early exits at E0, with done=1 for the cycle after E0 and state staying IDLE:
  - V==0: dz=1, ovf=0, Qo=0, R=0.
  - V≠0 and |D|[2N-1:N] ≥ |V|: ovf=1, dz=0, Qo=0, R=0.
  - Otherwise: state→DIV, busy=1.
- DIV, each edge:
  - T = {PR[N-1:0], QS[N-1]} − {0,|V|}, computed N+1 bits wide;
  - if T ≥ 0: PR=T and QS={QS[N-2:0],1};
  - else: PR={PR[N-1:0], QS[N-1]} and QS={QS[N-2:0],0};
  - Count−−. After the edge where Count reaches 0 (E_N), state→FIX.
- FIX, at edge E_{N+1}:
  - q = (sD^sV) ? −QS : QS; r = sD ? −PR[N-1:0] : PR[N-1:0].
  - Signed range check: if sD^sV=0 and QS > 2^(N-1)−1, or sD^sV=1 and QS > 2^(N-1), then ovf=1 and Qo=R=0. Otherwise register Qo=q[N-1:0], R=r, ovf=0, dz=0.
  - done=1 and busy=0; state→IDLE.
- Latency: normal completion has done high in the cycle after E_{N+1}, i.e. N+1 cycles after load (5 for N=4). Early exits take 1 cycle.
- done is high for exactly one cycle. Qo, R, dz and ovf hold their values until the next completion or reset.
- load while busy=1 is ignored, with no side effects and no queuing.
- Back-to-back: load high in the done cycle is sampled at the next edge in IDLE and accepted.
- Remainder is always below |V| ≤ 2^(N-1), so it fits in N signed bits.
- Most-negative cases are legal: D=−2^(2N-1) has magnitude representable in 2N bits unsigned, and V=−2^(N-1) has magnitude representable in N bits.
- D and V may change freely after the load edge; they are not re-sampled.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE, DIV, FIX};
  - default width constant DIV_N=4;
  - function returning the Count width for a given N.
- Sub-module mag_sign_conv, combinational and parameterised on width W: given a signed value, returns sign and unsigned magnitude; given a sign and a magnitude, returns the signed value. Used once each for the dividend, divisor, quotient fix and remainder fix.
- The top holds the FSM, the restoring datapath and the output registers.

Test Plan:
- D=15, V=5 (load one cycle) → done 5 cycles later: Qo=3, R=0, dz=0, ovf=0; busy high for exactly 5 cycles.
- D=−17 (8'hEF), V=5 → Qo=−3 (4'hD), R=−2 (4'hE). Repeat with D=30, V=−6 → Qo=−5, R=0. Repeat with D=17, V=−5 → Qo=−3, R=2.
- D=−32, V=4 → Qo=−8 (4'h8), R=0, ovf=0. D=32, V=4 → ovf=1 after 5 cycles, Qo=0. D=64, V=4 → ovf=1 after 1 cycle.
- V=0, D=15 → dz=1, Qo=0, R=0, done after 1 cycle. Next op D=15, V=3 → Qo=5, dz cleared.
- Start D=15, V=5, then assert reset at cycle 2 → busy=0, all outputs 0, no done. Then load D=−15, V=3 → Qo=−5, R=0.
- load pulsed mid-operation is ignored (result still 15/5=3). load held high through the done cycle starts a second op immediately, with done pulses spaced 6 cycles apart.
